// File: rtl/uart_bus_master.sv
// uart_bus_master
//   UART debug bridge acting as a bus initiator. Receives 8N1 command frames,
//   requests the CPU data bus, performs one 32-bit read or write, and answers
//   over its own 8N1 transmitter.
//
//   Commands (big-endian):  'R' A3 A2 A1 A0          -> D3 D2 D1 D0
//                           'W' A3..A0 D3..D0        -> 'K'
//                           unknown opcode / addr[1:0]!=0 -> '?'
//
// Ports:
//   sysclk     system clock
//   reset      asynchronous, active-low reset
//   uart_rx    serial command input (idle high)
//   uart_tx    serial response output (idle high)
//   bus_req    bus request, held through the access cycle
//   bus_gnt    grant from the CPU-side arbiter
//   bus_rd     one-cycle read strobe
//   bus_wr     one-cycle write strobe
//   bus_addr   access address (holds last value)
//   bus_wdata  write data (holds last value)
//   bus_rdata  read data, valid in the bus_rd cycle
//   busy       high from opcode accepted until last response bit sent
//
// Optional feature: define UART_BUS_MASTER_TIMEOUT_EN to abort a command that
// stalls for TIMEOUT_CYC cycles between bytes; the bridge then answers 'T'.
module uart_bus_master #(
  parameter int CLKS_PER_BIT = 10417
`ifdef UART_BUS_MASTER_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 2000000
`endif
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  localparam logic [31:0] BIT_LAST  = 32'(CLKS_PER_BIT - 1);
  localparam logic [31:0] HALF_LAST = 32'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]  OP_RD     = 8'h52;
  localparam logic [7:0]  OP_WR     = 8'h57;
  localparam logic [7:0]  RSP_OK    = 8'h4B;
  localparam logic [7:0]  RSP_ERR   = 8'h3F;
  localparam logic [7:0]  RSP_TO    = 8'h54;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, REQ, ACC, RESP} state_t;

  // ---------------- receiver ----------------
  logic        r_rx_meta, r_rx_sync, r_rx_prev, r_rx_active, r_rx_valid;
  logic [31:0] r_rx_cnt;
  logic [3:0]  r_rx_idx;   // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]  r_rx_shift, r_rx_byte;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1; r_rx_sync <= 1'b1; r_rx_prev <= 1'b1;
      r_rx_active <= 1'b0; r_rx_valid <= 1'b0;
      r_rx_cnt <= '0; r_rx_idx <= '0; r_rx_shift <= '0; r_rx_byte <= '0;
    end else begin
      r_rx_meta  <= uart_rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_valid <= 1'b0;
      if (!r_rx_active) begin
        if (r_rx_prev && !r_rx_sync) begin
          r_rx_active <= 1'b1;
          r_rx_cnt    <= '0;
          r_rx_idx    <= '0;
        end
      end else if (r_rx_idx == 4'd0) begin
        // Re-check the start bit at half a bit; a high level means a glitch.
        if (r_rx_cnt == HALF_LAST) begin
          r_rx_cnt <= '0;
          if (r_rx_sync) r_rx_active <= 1'b0;
          else           r_rx_idx    <= 4'd1;
        end else begin
          r_rx_cnt <= r_rx_cnt + 32'd1;
        end
      end else if (r_rx_cnt == BIT_LAST) begin
        r_rx_cnt <= '0;
        if (r_rx_idx == 4'd9) begin
          r_rx_active <= 1'b0;
          if (r_rx_sync) begin      // bad stop bit drops the byte silently
            r_rx_valid <= 1'b1;
            r_rx_byte  <= r_rx_shift;
          end
        end else begin
          r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
          r_rx_idx   <= r_rx_idx + 4'd1;
        end
      end else begin
        r_rx_cnt <= r_rx_cnt + 32'd1;
      end
    end
  end

  // ---------------- transmitter ----------------
  logic        r_tx_active, w_tx_ready, w_tx_start;
  logic [9:0]  r_tx_shift;
  logic [31:0] r_tx_cnt;
  logic [3:0]  r_tx_idx;
  logic [31:0] r_resp;
  logic [2:0]  r_resp_left;

  // Ready during the final stop-bit cycle so consecutive bytes have no gap.
  assign w_tx_ready = !r_tx_active || (r_tx_idx == 4'd9 && r_tx_cnt == BIT_LAST);
  assign uart_tx    = r_tx_shift[0];

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_tx_active <= 1'b0; r_tx_shift <= '1; r_tx_cnt <= '0; r_tx_idx <= '0;
    end else if (w_tx_start) begin
      r_tx_active <= 1'b1;
      r_tx_shift  <= {1'b1, r_resp[31:24], 1'b0};
      r_tx_cnt    <= '0;
      r_tx_idx    <= '0;
    end else if (r_tx_active) begin
      if (r_tx_cnt == BIT_LAST) begin
        r_tx_cnt   <= '0;
        r_tx_shift <= {1'b1, r_tx_shift[9:1]};
        if (r_tx_idx == 4'd9) r_tx_active <= 1'b0;
        else                  r_tx_idx    <= r_tx_idx + 4'd1;
      end else begin
        r_tx_cnt <= r_tx_cnt + 32'd1;
      end
    end
  end

  // ---------------- control ----------------
  state_t      r_state, w_state_next;
  logic        r_is_wr, w_resp_load, w_timeout;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_addr_sh, r_wdata_sh, r_bus_addr, r_bus_wdata, w_resp_val;
  logic [2:0]  w_resp_len;

  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;

`ifdef UART_BUS_MASTER_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        w_in_cmd;
  assign w_in_cmd = (r_state == ADDR) || (r_state == DATA);
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)                      r_to_cnt <= '0;
    else if (w_in_cmd && !r_rx_valid) r_to_cnt <= r_to_cnt + 32'd1;
    else                             r_to_cnt <= '0;
  end
  assign w_timeout = w_in_cmd && !r_rx_valid && (r_to_cnt == 32'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_resp_load  = 1'b0;
    w_resp_val   = 32'h0;
    w_resp_len   = 3'd0;
    w_tx_start   = 1'b0;
    bus_req      = 1'b0;
    bus_rd       = 1'b0;
    bus_wr       = 1'b0;
    busy         = (r_state != IDLE);
    case (r_state)
      IDLE: if (r_rx_valid) begin
        if (r_rx_byte == OP_RD || r_rx_byte == OP_WR) begin
          w_state_next = ADDR;
        end else begin
          w_state_next = RESP; w_resp_load = 1'b1;
          w_resp_val = {RSP_ERR, 24'h0}; w_resp_len = 3'd1;
        end
      end
      ADDR: if (w_timeout) begin
        w_state_next = RESP; w_resp_load = 1'b1;
        w_resp_val = {RSP_TO, 24'h0}; w_resp_len = 3'd1;
      end else if (r_rx_valid && r_byte_cnt == 2'd3) begin
        // Last byte is A0; its low bits decide alignment.
        if (r_rx_byte[1:0] != 2'b00) begin
          w_state_next = RESP; w_resp_load = 1'b1;
          w_resp_val = {RSP_ERR, 24'h0}; w_resp_len = 3'd1;
        end else begin
          w_state_next = r_is_wr ? DATA : REQ;
        end
      end
      DATA: if (w_timeout) begin
        w_state_next = RESP; w_resp_load = 1'b1;
        w_resp_val = {RSP_TO, 24'h0}; w_resp_len = 3'd1;
      end else if (r_rx_valid && r_byte_cnt == 2'd3) begin
        w_state_next = REQ;
      end
      REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) w_state_next = ACC;
      end
      ACC: begin
        bus_req = 1'b1; bus_rd = !r_is_wr; bus_wr = r_is_wr;
        w_state_next = RESP; w_resp_load = 1'b1;
        w_resp_val = r_is_wr ? {RSP_OK, 24'h0} : bus_rdata;
        w_resp_len = r_is_wr ? 3'd1 : 3'd4;
      end
      RESP: begin
        if (r_resp_left != 3'd0) begin
          if (w_tx_ready) w_tx_start = 1'b1;
        end else if (!r_tx_active) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_is_wr <= 1'b0; r_byte_cnt <= '0; r_addr_sh <= '0; r_wdata_sh <= '0;
      r_bus_addr <= '0; r_bus_wdata <= '0; r_resp <= '0; r_resp_left <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_byte_cnt <= '0;
          if (r_rx_valid) r_is_wr <= (r_rx_byte == OP_WR);
        end
        ADDR: if (r_rx_valid) begin
          r_addr_sh  <= {r_addr_sh[23:0], r_rx_byte};
          r_byte_cnt <= r_byte_cnt + 2'd1;
        end
        DATA: if (r_rx_valid) begin
          r_wdata_sh <= {r_wdata_sh[23:0], r_rx_byte};
          r_byte_cnt <= r_byte_cnt + 2'd1;
        end
        REQ: if (bus_gnt) begin
          // Latch outputs only for the access so they hold between commands.
          r_bus_addr <= r_addr_sh;
          if (r_is_wr) r_bus_wdata <= r_wdata_sh;
        end
        default: ;
      endcase
      if (w_resp_load) begin
        r_resp      <= w_resp_val;
        r_resp_left <= w_resp_len;
      end else if (w_tx_start) begin
        r_resp      <= {r_resp[23:0], 8'h00};
        r_resp_left <= r_resp_left - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Testbench for uart_bus_master with CLKS_PER_BIT=4. Define
// UART_BUS_MASTER_TIMEOUT_EN to also exercise the inter-byte timeout.
module tb_uart_bus_master;
  localparam int CPB = 4;

  logic        sysclk = 1'b0;
  logic        reset = 1'b0;
  logic        uart_rx = 1'b1;
  logic        uart_tx, bus_req, bus_rd, bus_wr, busy;
  logic        bus_gnt = 1'b1;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [31:0] tb_rdata = 32'h0;

  always #5 sysclk = ~sysclk;

  // Slave read data is only meaningful during the strobe cycle.
  assign bus_rdata = bus_rd ? tb_rdata : 32'hDEADBEEF;

  uart_bus_master #(
    .CLKS_PER_BIT(CPB)
`ifdef UART_BUS_MASTER_TIMEOUT_EN
    , .TIMEOUT_CYC(100)
`endif
  ) dut (
    .sysclk(sysclk), .reset(reset), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Cycle counter and bus monitor
  int          cyc = 0;
  int          wr_cnt = 0, rd_cnt = 0, req_cnt = 0;
  logic [31:0] wr_addr = '0, wr_data = '0, rd_addr = '0;

  always @(posedge sysclk) cyc <= cyc + 1;

  always @(negedge sysclk) begin
    if (bus_wr) begin wr_cnt <= wr_cnt + 1; wr_addr <= bus_addr; wr_data <= bus_wdata; end
    if (bus_rd) begin rd_cnt <= rd_cnt + 1; rd_addr <= bus_addr; end
    if (bus_req) req_cnt <= req_cnt + 1;
  end

  // Serial decoder for uart_tx, sampling near mid-bit on negedges
  logic [7:0] tx_bytes [0:255];
  int         tx_start [0:255];
  int         tx_n = 0;

  initial begin : tx_decoder
    logic [7:0] b;
    int t0;
    forever begin
      @(negedge sysclk);
      if (uart_tx === 1'b0) begin
        t0 = cyc;
        repeat (2) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge sysclk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge sysclk);
        tx_bytes[tx_n] = b;
        tx_start[tx_n] = t0;
        tx_n = tx_n + 1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge sysclk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge sysclk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge sysclk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge sysclk);
    uart_rx = 1'b1;
    repeat (2) @(negedge sysclk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
  endtask

  int rd_ptr = 0;

  // Waits (bounded) for n response bytes and for busy to fall.
  task automatic wait_resp(input int n, input string tag);
    int t;
    t = 0;
    while ((tx_n - rd_ptr) < n && t < 4000) begin @(negedge sysclk); t++; end
    t = 0;
    while (busy && t < 4000) begin @(negedge sysclk); t++; end
    repeat (CPB * 3) @(negedge sysclk);
    check({tag, "_nbytes"}, 32'(tx_n - rd_ptr), 32'(n));
    check({tag, "_idle"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    check(tag, {24'h0, tx_bytes[rd_ptr]}, {24'h0, exp});
    rd_ptr++;
  endtask

  int w0, r0, q0, cnt, s0;

  initial begin : main
    repeat (3) @(negedge sysclk);
    check("rst_tx", {31'h0, uart_tx}, 32'h1);
    check("rst_req", {31'h0, bus_req}, 32'h0);
    check("rst_rd", {31'h0, bus_rd}, 32'h0);
    check("rst_wr", {31'h0, bus_wr}, 32'h0);
    check("rst_addr", bus_addr, 32'h0);
    check("rst_wdata", bus_wdata, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    reset = 1'b1;
    repeat (4) @(negedge sysclk);

    // Write 0x000000A5 to 0x4000000C
    w0 = wr_cnt; r0 = rd_cnt;
    send_byte(8'h57, 1'b1);
    check("wr_busy", {31'h0, busy}, 32'h1);
    send_word(32'h4000000C);
    send_word(32'h000000A5);
    wait_resp(1, "wr");
    expect_byte("wr_resp", 8'h4B);
    check("wr_strobes", 32'(wr_cnt - w0), 32'd1);
    check("wr_no_rd", 32'(rd_cnt - r0), 32'd0);
    check("wr_addr", wr_addr, 32'h4000000C);
    check("wr_data", wr_data, 32'h000000A5);
    check("wr_addr_hold", bus_addr, 32'h4000000C);

    // Read 0x40000010 returning 0x0000005A, bytes back-to-back
    tb_rdata = 32'h0000005A;
    r0 = rd_cnt; w0 = wr_cnt;
    send_byte(8'h52, 1'b1);
    send_word(32'h40000010);
    s0 = rd_ptr;
    wait_resp(4, "rd");
    expect_byte("rd_b3", 8'h00);
    expect_byte("rd_b2", 8'h00);
    expect_byte("rd_b1", 8'h00);
    expect_byte("rd_b0", 8'h5A);
    for (int i = 0; i < 3; i++)
      check("rd_gap", 32'(tx_start[s0+i+1] - tx_start[s0+i]), 32'(10 * CPB));
    check("rd_strobes", 32'(rd_cnt - r0), 32'd1);
    check("rd_no_wr", 32'(wr_cnt - w0), 32'd0);
    check("rd_addr", rd_addr, 32'h40000010);

    // Grant withheld for 50 cycles
    tb_rdata = 32'h12345678;
    r0 = rd_cnt;
    bus_gnt = 1'b0;
    send_byte(8'h52, 1'b1);
    send_word(32'h40000014);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sysclk);
      if (bus_req && !bus_rd && !bus_wr) cnt++;
    end
    check("gnt_wait_cycles", 32'(cnt), 32'd50);
    bus_gnt = 1'b1;
    @(negedge sysclk);
    check("gnt_strobe", {31'h0, bus_rd}, 32'h1);
    check("gnt_req_acc", {31'h0, bus_req}, 32'h1);
    @(negedge sysclk);
    check("gnt_strobe_end", {31'h0, bus_rd}, 32'h0);
    check("gnt_req_drop", {31'h0, bus_req}, 32'h0);
    wait_resp(4, "gnt");
    expect_byte("gnt_b3", 8'h12);
    expect_byte("gnt_b2", 8'h34);
    expect_byte("gnt_b1", 8'h56);
    expect_byte("gnt_b0", 8'h78);
    check("gnt_strobes", 32'(rd_cnt - r0), 32'd1);

    // Unknown opcode, then misaligned read
    q0 = req_cnt;
    send_byte(8'h41, 1'b1);
    wait_resp(1, "badop");
    expect_byte("badop_resp", 8'h3F);
    send_byte(8'h52, 1'b1);
    send_word(32'h40000002);
    wait_resp(1, "misal");
    expect_byte("misal_resp", 8'h3F);
    check("err_no_req", 32'(req_cnt - q0), 32'd0);

    // Framing error on opcode, then a valid read
    tb_rdata = 32'hCAFEF00D;
    r0 = rd_cnt;
    send_byte(8'h52, 1'b0);
    repeat (10) @(negedge sysclk);
    check("frm_ignored", {31'h0, busy}, 32'h0);
    send_byte(8'h52, 1'b1);
    send_word(32'h40000020);
    wait_resp(4, "frm");
    expect_byte("frm_b3", 8'hCA);
    expect_byte("frm_b2", 8'hFE);
    expect_byte("frm_b1", 8'hF0);
    expect_byte("frm_b0", 8'h0D);
    check("frm_strobes", 32'(rd_cnt - r0), 32'd1);
    check("frm_addr", rd_addr, 32'h40000020);

`ifdef UART_BUS_MASTER_TIMEOUT_EN
    // Stalled command times out with 'T'
    r0 = rd_cnt; w0 = wr_cnt;
    send_byte(8'h52, 1'b1);
    send_byte(8'h40, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_resp(1, "to");
    expect_byte("to_resp", 8'h54);
    check("to_no_strobe", 32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);
`endif

    // Reset asserted mid-ADDR
    send_byte(8'h52, 1'b1);
    send_byte(8'h40, 1'b1);
    check("mid_busy", {31'h0, busy}, 32'h1);
    @(negedge sysclk);
    reset = 1'b0;
    #1;
    check("mrst_busy", {31'h0, busy}, 32'h0);
    check("mrst_addr", bus_addr, 32'h0);
    check("mrst_wdata", bus_wdata, 32'h0);
    check("mrst_req", {31'h0, bus_req}, 32'h0);
    check("mrst_tx", {31'h0, uart_tx}, 32'h1);
    repeat (2) @(negedge sysclk);
    reset = 1'b1;
    repeat (4) @(negedge sysclk);

    // Command after reset works normally
    tb_rdata = 32'h0BADCAFE;
    r0 = rd_cnt;
    send_byte(8'h52, 1'b1);
    send_word(32'h40000030);
    wait_resp(4, "post");
    expect_byte("post_b3", 8'h0B);
    expect_byte("post_b2", 8'hAD);
    expect_byte("post_b1", 8'hCA);
    expect_byte("post_b0", 8'hFE);
    check("post_strobes", 32'(rd_cnt - r0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
